switch_ingress_tx: RTL and testbench
====================================

Name: switch_ingress_tx

Overview:
- Per-port traffic transmitter that drives one ingress port of the switch fabric (data_in_valid / data_in / data_in_destination slice).
- Accepts burst commands over a valid/ready handshake.
- Emits formatted words tagged with source ID, destination and a per-destination sequence number, with programmable inter-word gap.
- One instance per switch input; the switch has no backpressure, so rate control is done here via gap and pause.

Parameters:
- DATA_WIDTH, 64, word width; must be >= 64.
- OUTPUT_QTY, 8, number of switch outputs; DEST_WIDTH = $clog2(OUTPUT_QTY), must be <= 8.
- SRC_ID, 0, 8-bit source identifier inserted in every word.
- SEQ_WIDTH, 16, per-destination sequence counter width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_dest  in  DEST_WIDTH  target switch output
- cmd_len  in  8  words in burst; 0 = no-op
- cmd_gap  in  4  idle cycles inserted between consecutive words
- cmd_seed  in  32  payload base value
- pause  in  1  stalls emission while high
- tx_valid  out  1  to switch data_in_valid[i]
- tx_data  out  DATA_WIDTH  to switch data_in[i]
- tx_dest  out  DEST_WIDTH  to switch data_in_destination[i]
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at burst completion
- words_sent  out  32  total words emitted since reset, wraps

Behaviour:
- Reset: state IDLE; all seq counters 0; words_sent 0; done 0; tx_valid 0; tx_data 0; tx_dest 0; busy 0; cmd_ready 1 from the first cycle after reset.
- Reset mid-burst aborts the burst with no done pulse; tx_valid is low the cycle after reset is sampled.
- Word format, bit 63 = MSB:
  - [63:56] SRC_ID
  - [55:48] dest, zero-extended
  - [47:32] sequence number
  - [31:0] cmd_seed + word index (index 0-based, 32-bit wrap)
  - bits above 63 are zero.
- FSM states IDLE, SEND, GAP.
- IDLE:
  - Handshake = cmd_valid & cmd_ready.
  - On handshake with cmd_len == 0: done = 1 next cycle; stay IDLE.
  - On handshake with cmd_len != 0: latch dest, len, gap, seed; index = 0; go to SEND.
- SEND:
  - tx_valid = !pause (combinational from state and pause).
  - tx_data and tx_dest come from registered fields only.
  - When pause = 1: no emission, no counter change, stay SEND.
  - When emitting: seq[dest]++ (wraps 0xFFFF -> 0), words_sent++, index++.
  - After the last word: go to IDLE; done = 1 in that IDLE cycle, where cmd_ready is also 1.
  - Otherwise, cmd_gap == 0: stay SEND (back-to-back words); cmd_gap != 0: go to GAP with gap_cnt = cmd_gap.
- GAP:
  - tx_valid = 0.
  - gap_cnt decrements every cycle regardless of pause; at gap_cnt == 1, go to SEND.
  - Exactly cmd_gap idle cycles between words.
- Latency: handshake in cycle N puts the first word on tx_valid in cycle N+1 (if not paused).
- Burst duration: len + (len-1)*gap cycles, plus pause cycles.
- Sequence counters persist across bursts and are cleared only by reset.
- A new command accepted in the done cycle is legal; it yields back-to-back bursts with one IDLE cycle between them.
- done is never asserted on the same cycle as tx_valid.

Decomposition:
- Shared package switch_pkg holds:
  - header field LSB/MSB constants (SRC_LSB = 56, DEST_LSB = 48, SEQ_LSB = 32, PAYLOAD_LSB = 0)
  - tx_state_t enum {IDLE, SEND, GAP}
  - a word-packing function pack_word(src, dest, seq, payload).
- The egress checker reuses switch_pkg for unpacking.
- No sub-module is required; the sequence counter bank stays inline as an array of OUTPUT_QTY x SEQ_WIDTH registers.

Test Plan:
- Single burst: dest = 3, len = 4, gap = 0, seed = 0x100, SRC_ID = 2.
  - tx_valid high for 4 consecutive cycles starting the cycle after handshake.
  - tx_data[31:0] = 0x100..0x103; [47:32] = 0..3; [63:56] = 0x02; tx_dest = 3.
  - done one cycle after the last word; words_sent = 4.
- Gap: dest = 1, len = 3, gap = 2.
  - Valid pattern 1,0,0,1,0,0,1 then done.
  - busy high for 7 cycles.
- Sequence continuity and isolation: burst dest = 5 len = 2, burst dest = 6 len = 1, burst dest = 5 len = 2.
  - dest 5 sequence numbers 0,1,2,3; dest 6 sequence number 0.
- Pause: len = 3, gap = 0, pause held high for 2 cycles after the first word.
  - Words 0,(stall),(stall),1,2; sequence numbers and payload contiguous; words_sent = 3.
- Edge cases:
  - len = 0: done pulse, no tx_valid, counters unchanged.
  - seed = 0xFFFFFFFF, len = 2: payloads 0xFFFFFFFF then 0x00000000.
  - Preload by 65536 words to dest 0: sequence wraps to 0.
- Reset mid-burst: len = 10, reset asserted after word 4.
  - tx_valid 0 the next cycle, no done pulse.
  - Next burst to the same dest starts at sequence 0; words_sent = 0.

Source files
------------

// File: rtl/switch_pkg.sv
// switch_pkg: shared word layout, transmitter state encoding and word packing for the switch fabric.
package switch_pkg;

    localparam int WORD_WIDTH  = 64;
    localparam int SRC_LSB     = 56;
    localparam int DEST_LSB    = 48;
    localparam int SEQ_LSB     = 32;
    localparam int PAYLOAD_LSB = 0;

    typedef enum logic [1:0] {IDLE, SEND, GAP} tx_state_t;

    function automatic logic [WORD_WIDTH-1:0] pack_word(
        input logic [7:0]  src,
        input logic [7:0]  dest,
        input logic [15:0] seq,
        input logic [31:0] payload
    );
        logic [WORD_WIDTH-1:0] w;
        w = '0;
        w[SRC_LSB +: 8]      = src;
        w[DEST_LSB +: 8]     = dest;
        w[SEQ_LSB +: 16]     = seq;
        w[PAYLOAD_LSB +: 32] = payload;
        return w;
    endfunction

endpackage

// File: rtl/switch_ingress_tx.sv
// switch_ingress_tx: per-port burst transmitter feeding one switch ingress with tagged, sequenced words.
module switch_ingress_tx
    import switch_pkg::*;
#(
    parameter int         DATA_WIDTH = 64,
    parameter int         OUTPUT_QTY = 8,
    parameter logic [7:0] SRC_ID     = 8'd0,
    parameter int         SEQ_WIDTH  = 16,
    localparam int        DEST_WIDTH = $clog2(OUTPUT_QTY)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [DEST_WIDTH-1:0] cmd_dest,
    input  logic [7:0]            cmd_len,
    input  logic [3:0]            cmd_gap,
    input  logic [31:0]           cmd_seed,
    input  logic                  pause,
    output logic                  tx_valid,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic [DEST_WIDTH-1:0] tx_dest,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           words_sent
);

    tx_state_t             state_q;
    logic [DEST_WIDTH-1:0] dest_q;
    logic [7:0]            len_q, idx_q;
    logic [3:0]            gap_q, gap_cnt_q;
    logic [31:0]           seed_q, words_q;
    logic [SEQ_WIDTH-1:0]  seq_q [OUTPUT_QTY];
    logic                  done_q, sending, emit, last;

    assign sending    = state_q == SEND;
    assign emit       = sending && !pause;
    assign last       = idx_q == len_q - 8'd1;
    assign cmd_ready  = state_q == IDLE;
    assign busy       = state_q != IDLE;
    assign done       = done_q;
    assign words_sent = words_q;
    assign tx_valid   = emit;
    // Data/dest depend only on registered state, so pause never ripples into the datapath.
    assign tx_dest    = sending ? dest_q : '0;
    assign tx_data    = sending ? DATA_WIDTH'(pack_word(SRC_ID, 8'(dest_q), 16'(seq_q[dest_q]),
                                                        seed_q + 32'(idx_q))) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            done_q    <= 1'b0;
            words_q   <= '0;
            dest_q    <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            gap_q     <= '0;
            gap_cnt_q <= '0;
            seed_q    <= '0;
            for (int i = 0; i < OUTPUT_QTY; i++) seq_q[i] <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (cmd_valid) begin
                    if (cmd_len == 8'd0) done_q <= 1'b1;
                    else begin
                        dest_q  <= cmd_dest;
                        len_q   <= cmd_len;
                        gap_q   <= cmd_gap;
                        seed_q  <= cmd_seed;
                        idx_q   <= 8'd0;
                        state_q <= SEND;
                    end
                end
                SEND: if (!pause) begin
                    seq_q[dest_q] <= seq_q[dest_q] + SEQ_WIDTH'(1);
                    words_q       <= words_q + 32'd1;
                    idx_q         <= idx_q + 8'd1;
                    if (last) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end else if (gap_q != 4'd0) begin
                        state_q   <= GAP;
                        gap_cnt_q <= gap_q;
                    end
                end
                GAP: begin
                    gap_cnt_q <= gap_cnt_q - 4'd1;
                    if (gap_cnt_q == 4'd1) state_q <= SEND;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_switch_ingress_tx.sv
// tb_switch_ingress_tx: randomized bursts checked against a schedule/format reference model.
module tb_switch_ingress_tx;

    localparam logic [7:0] SRC = 8'h02;

    logic        clk = 1'b0, reset = 1'b1, cmd_valid = 1'b0, pause = 1'b0;
    logic [2:0]  cmd_dest = '0;
    logic [7:0]  cmd_len = '0;
    logic [3:0]  cmd_gap = '0;
    logic [31:0] cmd_seed = '0;
    logic        cmd_ready, tx_valid, busy, done;
    logic [63:0] tx_data;
    logic [2:0]  tx_dest;
    logic [31:0] words_sent;

    int          compared = 0, mismatched = 0;
    logic [15:0] seq_m [8];
    logic [31:0] words_m;

    switch_ingress_tx #(.DATA_WIDTH(64), .OUTPUT_QTY(8), .SRC_ID(SRC), .SEQ_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dest(cmd_dest), .cmd_len(cmd_len), .cmd_gap(cmd_gap), .cmd_seed(cmd_seed),
        .pause(pause), .tx_valid(tx_valid), .tx_data(tx_data), .tx_dest(tx_dest),
        .busy(busy), .done(done), .words_sent(words_sent)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) seq_m[i] = '0;
        words_m = '0;
    endtask

    // Called at negedge+1 of an IDLE cycle; returns at negedge+1 of the done cycle.
    // Word k may go out at the first unpaused cycle at least gap+1 cycles after word k-1.
    task automatic burst(input logic [2:0] dest, input logic [7:0] len, input logic [3:0] gap,
                         input logic [31:0] seed, input logic [31:0] pmask, input int ppct);
        int   c, next_at, k;
        logic p, ev;
        cmd_valid = 1'b1; cmd_dest = dest; cmd_len = len; cmd_gap = gap; cmd_seed = seed; pause = 1'b0;
        check("cmd_ready", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        c = 1; next_at = 1; k = 0;
        while (k < int'(len) && c <= 4000) begin
            p = (c <= 32 ? pmask[c-1] : 1'b0) || ($urandom_range(99) < ppct);
            pause = p;
            #1;
            ev = (c >= next_at) && !p;
            check("tx_valid", tx_valid, ev);
            check("busy", busy, 1);
            check("done_early", done, 0);
            if (ev) begin
                check("tx_data", tx_data, {SRC, 5'b0, dest, seq_m[dest], seed + 32'(k)});
                check("tx_dest", tx_dest, dest);
                seq_m[dest]++;
                words_m++;
                k++;
                next_at = c + int'(gap) + 1;
            end
            @(negedge clk);
            c++;
        end
        check("burst_len", k, len);
        pause = 1'b0;
        #1;
        check("done", done, 1);
        check("tx_valid_done", tx_valid, 0);
        check("busy_done", busy, 0);
        check("cmd_ready_done", cmd_ready, 1);
        check("words_sent", words_sent, words_m);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("rst_tx_valid", tx_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_words", words_sent, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_tx_dest", tx_dest, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_cmd_ready", cmd_ready, 1);

        burst(3'd3, 8'd4, 4'd0, 32'h100, 32'h0, 0);
        burst(3'd1, 8'd3, 4'd2, $urandom, 32'h0, 0);
        burst(3'd5, 8'd2, 4'd0, $urandom, 32'h0, 0);
        burst(3'd6, 8'd1, 4'd0, $urandom, 32'h0, 0);
        burst(3'd5, 8'd2, 4'd0, $urandom, 32'h0, 0);
        burst(3'd2, 8'd3, 4'd0, $urandom, 32'h6, 0);
        burst(3'd4, 8'd0, 4'd3, $urandom, 32'h0, 0);
        burst(3'd7, 8'd2, 4'd0, 32'hFFFF_FFFF, 32'h0, 0);

        repeat (30) begin
            burst(3'($urandom_range(7)), 8'($urandom_range(12)), 4'($urandom_range(15)),
                  $urandom, 32'h0, 20);
            if ($urandom_range(1) == 1) begin
                @(negedge clk);
                #1;
                check("idle_done", done, 0);
            end
        end

        // Abort a burst with reset after four words.
        cmd_valid = 1'b1; cmd_dest = 3'd4; cmd_len = 8'd10; cmd_gap = 4'd0; pause = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (4) begin
            #1;
            check("pre_reset_valid", tx_valid, 1);
            @(negedge clk);
        end
        reset = 1'b1;
        pause = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        pause = 1'b0;
        #1;
        check("abort_tx_valid", tx_valid, 0);
        check("abort_done", done, 0);
        check("abort_busy", busy, 0);
        check("abort_words", words_sent, 0);
        check("abort_cmd_ready", cmd_ready, 1);
        @(negedge clk);
        #1;
        check("abort_done_late", done, 0);
        model_reset();
        burst(3'd4, 8'd3, 4'd0, $urandom, 32'h0, 0);

        // 65536 words to dest 0 so its sequence number wraps back to 0.
        for (int i = 0; i < 257; i++) burst(3'd0, 8'd255, 4'd0, 32'(i), 32'h0, 0);
        burst(3'd0, 8'd1, 4'd0, $urandom, 32'h0, 0);
        burst(3'd0, 8'd2, 4'd0, $urandom, 32'h0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
